// File: rtl/pcie_cq_ats_inv_responder_if.sv
// AXI-Stream bundle for the CQ input, CQ pass-through and RQ completion paths.
// Master drives data/valid/last/user; slave returns tready.
interface pcie_cq_ats_inv_responder_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 228
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [USER_W-1:0]   tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/pcie_cq_ats_inv_responder.sv
// CQ snooper: zero-latency pass-through; ATS Invalidate Requests are queued and answered with one
// single-beat Invalidate Completion each on RQ, held until rq tready; FIFO-full requests are counted drops.
module pcie_cq_ats_inv_responder #(
  parameter int          AXIS_DATA_WIDTH  = 512,
  parameter int          AXIS_TUSER_WIDTH = 228,
  parameter int          FIFO_DEPTH       = 8,
  parameter logic [3:0]  REQ_TYPE_MATCH   = 4'hE,
  parameter logic [7:0]  INV_REQ_CODE     = 8'h01,
  parameter logic [7:0]  INV_CPL_CODE     = 8'h02,
  parameter int          CNT_WIDTH        = 16,
  localparam int         LVL_W            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pcie_cq_ats_inv_responder_if.slave  s_axis,
  pcie_cq_ats_inv_responder_if.master m_axis,
  pcie_cq_ats_inv_responder_if.master rq_axis,
  input  logic                  cfg_enable,
  output logic                  ats_hit,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  ovf_sticky,
  output logic [CNT_WIDTH-1:0]  inv_req_cnt,
  output logic [CNT_WIDTH-1:0]  inv_cpl_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic             sop, accepted, match, full, push, hs, load;
  logic [23:0]      in_ent, cur_ent;
  logic [23:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [LVL_W-1:0] count, count_rem;

  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tvalid = s_axis.tvalid;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tuser  = AXIS_TUSER_WIDTH'(s_axis.tuser);
  assign s_axis.tready = m_axis.tready;
  assign rq_axis.tuser = '0;

  assign accepted = s_axis.tvalid & m_axis.tready;
  assign in_ent   = {s_axis.tdata[95:80], s_axis.tdata[103:96]};
  assign match    = accepted & sop & cfg_enable &
                    (s_axis.tdata[78:75] == REQ_TYPE_MATCH) &
                    (s_axis.tdata[111:104] == INV_REQ_CODE);
  assign full     = (count == LVL_W'(FIFO_DEPTH));
  assign push     = match & ~full;
  // The entry under transmission stays in the FIFO until its beat is accepted.
  assign hs        = (state == SEND) & rq_axis.tready;
  assign count_rem = count - LVL_W'(hs);
  assign rd_nxt    = rd_ptr + AW'(hs);
  assign load      = ((state == IDLE) | hs) & (state_nxt == SEND);
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if ((count != '0) || push) state_nxt = SEND;
      SEND: if (hs && (count_rem == '0) && !push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rq_axis.tvalid = 1'b0;
    rq_axis.tlast  = 1'b0;
    rq_axis.tkeep  = '0;
    rq_axis.tdata  = '0;
    if (state == SEND) begin
      rq_axis.tvalid           = 1'b1;
      rq_axis.tlast            = 1'b1;
      rq_axis.tkeep[15:0]      = '1;
      rq_axis.tdata[2:0]       = 3'b001;
      rq_axis.tdata[78:75]     = REQ_TYPE_MATCH;
      rq_axis.tdata[95:80]     = cur_ent[23:8];
      rq_axis.tdata[103:96]    = cur_ent[7:0];
      rq_axis.tdata[111:104]   = INV_CPL_CODE;
      rq_axis.tdata[114:112]   = 3'b010;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sop         <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur_ent     <= '0;
      ats_hit     <= 1'b0;
      ovf_sticky  <= 1'b0;
      inv_req_cnt <= '0;
      inv_cpl_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (accepted) sop <= s_axis.tlast;
      ats_hit <= match;
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_nxt;
      count   <= count + LVL_W'(push) - LVL_W'(hs);
      // With nothing left behind the departing entry, the incoming request goes straight out.
      if (load) cur_ent <= (count_rem != '0) ? mem[rd_nxt] : in_ent;
      if (match && (inv_req_cnt != '1)) inv_req_cnt <= inv_req_cnt + 1'b1;
      if (match && full) begin
        ovf_sticky <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (hs && (inv_cpl_cnt != '1)) inv_cpl_cnt <= inv_cpl_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pcie_cq_ats_inv_responder.sv
// Directed bench: queue-level reference model checked every cycle plus literal spot checks.
module tb_pcie_cq_ats_inv_responder;
  localparam int DW = 512, UW = 228, DEPTH = 8, CW = 4, LW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst = 1'b1, cfg_enable = 1'b1;
  always #5 clk = ~clk;

  logic          ats_hit, ovf_sticky;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] inv_req_cnt, inv_cpl_cnt, drop_cnt;

  pcie_cq_ats_inv_responder_if #(.DATA_W(DW), .USER_W(UW)) cq();
  pcie_cq_ats_inv_responder_if #(.DATA_W(DW), .USER_W(UW)) usr();
  pcie_cq_ats_inv_responder_if #(.DATA_W(DW), .USER_W(1))  rq();

  pcie_cq_ats_inv_responder #(
    .AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .s_axis(cq), .m_axis(usr), .rq_axis(rq),
    .cfg_enable(cfg_enable), .ats_hit(ats_hit), .fifo_level(fifo_level),
    .ovf_sticky(ovf_sticky), .inv_req_cnt(inv_req_cnt), .inv_cpl_cnt(inv_cpl_cnt),
    .drop_cnt(drop_cnt)
  );

  int n_cmp = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending completions as a queue; head is what RQ must present.
  bit          m_sop = 1'b1, m_hit = 1'b0, m_ovf = 1'b0;
  logic [23:0] m_q[$];
  int          m_req = 0, m_cpl = 0, m_drop = 0;

  function automatic logic [DW-1:0] cpl_desc(input logic [23:0] e);
    logic [DW-1:0] d = '0;
    d[2:0] = 3'b001; d[78:75] = 4'hE; d[95:80] = e[23:8]; d[103:96] = e[7:0];
    d[111:104] = 8'h02; d[114:112] = 3'b010;
    return d;
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_step();
    bit acc, mt;
    int occ;
    if (rst) begin
      m_sop = 1'b1; m_q.delete(); m_hit = 1'b0; m_ovf = 1'b0;
      m_req = 0; m_cpl = 0; m_drop = 0;
    end else begin
      acc = cq.tvalid && usr.tready;
      mt  = acc && m_sop && cfg_enable && (cq.tdata[78:75] == 4'hE) && (cq.tdata[111:104] == 8'h01);
      occ = m_q.size();
      if (occ > 0 && rq.tready) begin
        void'(m_q.pop_front());
        m_cpl = sat(m_cpl);
      end
      m_hit = mt;
      if (mt) begin
        m_req = sat(m_req);
        if (occ == DEPTH) begin m_drop = sat(m_drop); m_ovf = 1'b1; end
        else m_q.push_back({cq.tdata[95:80], cq.tdata[103:96]});
      end
      if (acc) m_sop = cq.tlast;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      logic [DW/8-1:0] k;
      bit ev;
      ev = (m_q.size() > 0);
      k = '0;
      if (ev) k[15:0] = '1;
      chk("rq_tvalid", DW'(rq.tvalid), DW'(ev));
      chk("rq_tlast", DW'(rq.tlast), DW'(ev));
      chk("rq_tkeep", DW'(rq.tkeep), DW'(k));
      if (ev) chk("rq_tdata", rq.tdata, cpl_desc(m_q[0]));
      chk("ats_hit", DW'(ats_hit), DW'(m_hit));
      chk("fifo_level", DW'(fifo_level), DW'(m_q.size()));
      chk("ovf_sticky", DW'(ovf_sticky), DW'(m_ovf));
      chk("inv_req_cnt", DW'(inv_req_cnt), DW'(m_req));
      chk("inv_cpl_cnt", DW'(inv_cpl_cnt), DW'(m_cpl));
      chk("drop_cnt", DW'(drop_cnt), DW'(m_drop));
      chk("pt_tvalid", DW'(usr.tvalid), DW'(cq.tvalid));
      chk("pt_tdata", usr.tdata, cq.tdata);
      chk("pt_tkeep", DW'(usr.tkeep), DW'(cq.tkeep));
      chk("pt_tlast", DW'(usr.tlast), DW'(cq.tlast));
      chk("pt_tuser", DW'(usr.tuser), DW'(cq.tuser));
      chk("pt_tready", DW'(cq.tready), DW'(usr.tready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [3:0] rt, input logic [7:0] mc, input logic [15:0] id,
                      input logic [7:0] tg, input logic last);
    logic [DW-1:0] d;
    logic [255:0]  u;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) u[i*32 +: 32] = $urandom;
    d[78:75] = rt; d[111:104] = mc; d[95:80] = id; d[103:96] = tg;
    cq.tdata  = d;
    cq.tkeep  = {$urandom, $urandom};
    cq.tuser  = u[UW-1:0];
    cq.tvalid = 1'b1;
    cq.tlast  = last;
    tick();
  endtask

  task automatic idle(input int n);
    cq.tvalid = 1'b0;
    cq.tlast  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    cq.tvalid = 1'b0; cq.tdata = '0; cq.tkeep = '0; cq.tlast = 1'b0; cq.tuser = '0;
    usr.tready = 1'b1; rq.tready = 1'b1;
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_level", DW'(fifo_level), DW'(0));
    chk("rst_tvalid", DW'(rq.tvalid), DW'(0));
    chk("rst_tdata", rq.tdata, '0);
    chk("rst_req_cnt", DW'(inv_req_cnt), DW'(0));
    rst = 1'b0;
    tick();

    // single invalidate, RQ ready
    beat(4'hE, 8'h01, 16'h0100, 8'h05, 1'b1);
    chk("t1_hit", DW'(ats_hit), DW'(1));
    chk("t1_tvalid", DW'(rq.tvalid), DW'(1));
    chk("t1_tag", DW'(rq.tdata[103:96]), DW'(8'h05));
    chk("t1_reqid", DW'(rq.tdata[95:80]), DW'(16'h0100));
    chk("t1_code", DW'(rq.tdata[111:104]), DW'(8'h02));
    chk("t1_tlast", DW'(rq.tlast), DW'(1));
    idle(1);
    chk("t1_req_cnt", DW'(inv_req_cnt), DW'(1));
    chk("t1_cpl_cnt", DW'(inv_cpl_cnt), DW'(1));
    chk("t1_idle", DW'(rq.tvalid), DW'(0));

    // RQ backpressure for 10 cycles
    rq.tready = 1'b0;
    beat(4'hE, 8'h01, 16'h0100, 8'h05, 1'b1);
    idle(10);
    chk("t2_held", DW'(rq.tvalid), DW'(1));
    chk("t2_tag", DW'(rq.tdata[103:96]), DW'(8'h05));
    chk("t2_cpl_wait", DW'(inv_cpl_cnt), DW'(1));
    rq.tready = 1'b1;
    tick();
    chk("t2_cpl_cnt", DW'(inv_cpl_cnt), DW'(2));

    // overflow: 10 requests into 8 slots
    rq.tready = 1'b0;
    for (int i = 0; i < 10; i++) beat(4'hE, 8'h01, 16'h0200 + 16'(i), 8'h10 + 8'(i), 1'b1);
    idle(1);
    chk("t3_level", DW'(fifo_level), DW'(8));
    chk("t3_drop", DW'(drop_cnt), DW'(2));
    chk("t3_ovf", DW'(ovf_sticky), DW'(1));
    chk("t3_req", DW'(inv_req_cnt), DW'(12));
    rq.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_burst_vld", DW'(rq.tvalid), DW'(1));
      chk("t3_burst_tag", DW'(rq.tdata[103:96]), DW'(8'h10 + 8'(i)));
      tick();
    end
    chk("t3_drained", DW'(rq.tvalid), DW'(0));
    chk("t3_cpl", DW'(inv_cpl_cnt), DW'(10));

    // non-SOP lookalike, wrong req_type, unaccepted beat
    beat(4'h0, 8'h00, 16'h0000, 8'h00, 1'b0);
    beat(4'hE, 8'h01, 16'h0300, 8'h20, 1'b1);
    chk("t4_nonsop_hit", DW'(ats_hit), DW'(0));
    beat(4'hC, 8'h01, 16'h0301, 8'h21, 1'b1);
    chk("t4_type_hit", DW'(ats_hit), DW'(0));
    usr.tready = 1'b0;
    beat(4'hE, 8'h01, 16'h0302, 8'h22, 1'b1);
    chk("t4_noacc_hit", DW'(ats_hit), DW'(0));
    usr.tready = 1'b1;
    beat(4'hE, 8'h01, 16'h0303, 8'h23, 1'b1);
    chk("t4_hit", DW'(ats_hit), DW'(1));
    chk("t4_req", DW'(inv_req_cnt), DW'(13));
    idle(2);

    // cfg_enable=0 with 3 queued; enable only matters on the SOP beat
    rq.tready = 1'b0;
    for (int i = 0; i < 3; i++) beat(4'hE, 8'h01, 16'h0400 + 16'(i), 8'h30 + 8'(i), 1'b1);
    cfg_enable = 1'b0;
    beat(4'hE, 8'h01, 16'h0410, 8'h40, 1'b1);
    beat(4'hE, 8'h01, 16'h0411, 8'h41, 1'b0);
    cfg_enable = 1'b1;
    beat(4'hE, 8'h01, 16'h0412, 8'h42, 1'b1);
    idle(1);
    chk("t5_level", DW'(fifo_level), DW'(3));
    chk("t5_req_sat", DW'(inv_req_cnt), DW'(15));
    rq.tready = 1'b1;
    idle(4);
    chk("t5_cpl", DW'(inv_cpl_cnt), DW'(14));
    chk("t5_level0", DW'(fifo_level), DW'(0));

    // reset while sending with 4 pending
    rq.tready = 1'b0;
    for (int i = 0; i < 4; i++) beat(4'hE, 8'h01, 16'h0500 + 16'(i), 8'h50 + 8'(i), 1'b1);
    idle(1);
    chk("t6_level", DW'(fifo_level), DW'(4));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_tvalid", DW'(rq.tvalid), DW'(0));
    chk("t6_level", DW'(fifo_level), DW'(0));
    chk("t6_req", DW'(inv_req_cnt), DW'(0));
    chk("t6_cpl", DW'(inv_cpl_cnt), DW'(0));
    chk("t6_drop", DW'(drop_cnt), DW'(0));
    chk("t6_ovf", DW'(ovf_sticky), DW'(0));

    // back-to-back stream with RQ ready: no bubbles, counters saturate
    rq.tready = 1'b1;
    for (int i = 0; i < 17; i++) beat(4'hE, 8'h01, 16'h0600 + 16'(i), 8'h60 + 8'(i), 1'b1);
    chk("t7_level", DW'(fifo_level), DW'(1));
    chk("t7_tag", DW'(rq.tdata[103:96]), DW'(8'h70));
    idle(2);
    chk("t7_req_sat", DW'(inv_req_cnt), DW'(15));
    chk("t7_cpl_sat", DW'(inv_cpl_cnt), DW'(15));
    chk("t7_drop", DW'(drop_cnt), DW'(0));

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
